// File: rtl/dma_chan_sched.sv
// Round-robin front end that shares one DMA engine between NUM_CH requesters.
// It grants one descriptor at a time, drives the engine go/descriptor handshake,
// and reports a per-channel done/error pulse when the engine finishes.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no owner; arbitrate and capture winner's descriptor
// LOCAL    | zero-length descriptor, completed without touching the engine
// GO       | go asserted, waiting for the engine to show active or done
// WAIT     | engine running, waiting for done
// RELEASE  | go dropped, waiting for the engine to clear done

package dma_pkg;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic done;
    logic active;
    logic error;
  } s_dma_status_t;

  typedef enum logic [1:0] {
    DMA_ERR_NONE = 2'd0,
    DMA_ERR_RD   = 2'd1,
    DMA_ERR_WR   = 2'd2,
    DMA_ERR_CFG  = 2'd3
  } e_dma_err_src_t;

  typedef struct packed {
    e_dma_err_src_t src;
    logic [31:0]    addr;
  } s_dma_error_t;

endpackage

module dma_chan_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_CH-1:0]           ch_req_i,
  input  s_dma_desc_t [NUM_CH-1:0]    ch_desc_i,
  output logic [NUM_CH-1:0]           ch_ack_o,
  output logic [NUM_CH-1:0]           ch_done_o,
  output logic [NUM_CH-1:0]           ch_err_o,
  output s_dma_error_t                err_info_o,
  output logic                        timeout_o,
  output logic                        busy_o,
  output logic [$clog2(NUM_CH)-1:0]   cur_ch_o,
  output logic                        dma_go_o,
  output s_dma_desc_t                 dma_desc_o,
  input  s_dma_status_t               dma_stats_i,
  input  s_dma_error_t                dma_error_i
);

  localparam int          CW       = $clog2(NUM_CH);
  localparam bit          WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOCAL   = 3'd1,
    S_GO      = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_q;
  logic [CW-1:0]     grant_idx;
  logic              grant_vld;
  logic              in_run;
  logic              rel_first_q;
  logic              local_done_q;
  logic [15:0]       wdog_q;
  logic              err_flag_q;
  logic              eng_err_seen_q;
  logic              err_cap;

  assign in_run   = (state_q == S_GO) || (state_q == S_WAIT);
  assign busy_o   = (state_q != S_IDLE);
  assign dma_go_o = in_run;
  assign timeout_o = WDOG_EN && in_run && (wdog_q == TMO_LAST);

  // Engine error counts while running and on the cycle done is reported.
  assign err_cap = dma_stats_i.error && (in_run || ((state_q == S_RELEASE) && rel_first_q));

  // Pick the first requester after the last winner, wrapping around.
  always_comb begin
    logic [CW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CW'((int'(rr_q) + i) % NUM_CH);
      if (!grant_vld && ch_req_i[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = (ch_desc_i[grant_idx].num_bytes == 16'd0) ? S_LOCAL : S_GO;
        end
      end
      S_LOCAL:   state_d = S_IDLE;
      S_GO:      if (dma_stats_i.active || dma_stats_i.done) state_d = S_WAIT;
      S_WAIT:    if (dma_stats_i.done) state_d = S_RELEASE;
      S_RELEASE: if (!dma_stats_i.done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Grant capture: descriptor, owner, rotation pointer and ack pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q       <= CW'(NUM_CH - 1);
      cur_ch_o   <= '0;
      dma_desc_o <= '0;
      ch_ack_o   <= '0;
    end else begin
      ch_ack_o <= '0;
      if ((state_q == S_IDLE) && grant_vld) begin
        rr_q                <= grant_idx;
        cur_ch_o            <= grant_idx;
        dma_desc_o          <= ch_desc_i[grant_idx];
        ch_ack_o[grant_idx] <= 1'b1;
      end
    end
  end

  // Completion markers: the done pulse lands one cycle after LOCAL or on RELEASE entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rel_first_q  <= 1'b0;
      local_done_q <= 1'b0;
    end else begin
      rel_first_q  <= (state_q == S_WAIT) && dma_stats_i.done;
      local_done_q <= (state_q == S_LOCAL);
    end
  end

  // Watchdog: counts GO/WAIT cycles, saturates, clears when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q <= '0;
    end else if (state_q == S_IDLE) begin
      wdog_q <= '0;
    end else if (in_run && (wdog_q != 16'hFFFF)) begin
      wdog_q <= wdog_q + 16'd1;
    end
  end

  // Sticky per-transfer error state; err_info keeps the first engine error of a transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_flag_q     <= 1'b0;
      eng_err_seen_q <= 1'b0;
      err_info_o     <= '0;
    end else if (state_q == S_IDLE) begin
      err_flag_q     <= 1'b0;
      eng_err_seen_q <= 1'b0;
    end else begin
      if (err_cap || timeout_o) err_flag_q <= 1'b1;
      if (err_cap) begin
        eng_err_seen_q <= 1'b1;
        if (!eng_err_seen_q) err_info_o <= dma_error_i;
      end
    end
  end

  // Per-channel completion report for the current owner.
  always_comb begin
    ch_done_o = '0;
    ch_err_o  = '0;
    if (rel_first_q) begin
      ch_done_o[cur_ch_o] = 1'b1;
      ch_err_o[cur_ch_o]  = err_flag_q || dma_stats_i.error;
    end else if (local_done_q) begin
      ch_done_o[cur_ch_o] = 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: a simple engine model answers go with
// done after a programmable latency; instance B runs with a short watchdog.
module tb_dma_chan_sched;
  import dma_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [3:0]            ch_req;
  s_dma_desc_t [3:0]     ch_desc;
  s_dma_status_t         dma_stats;
  s_dma_error_t          dma_error;

  logic [3:0]   ack_a, done_a, err_a, ack_b, done_b, err_b;
  s_dma_error_t err_info_a, err_info_b;
  logic         timeout_a, timeout_b, busy_a, busy_b, go_a, go_b;
  logic [1:0]   cur_ch_a, cur_ch_b;
  s_dma_desc_t  desc_a, desc_b;

  int n_cmp = 0;
  int n_bad = 0;
  int overlap_n = 0;

  int           eng_lat = 10;
  bit           eng_hang = 1'b0;
  bit           eng_force = 1'b0;
  int           eng_err_at = 0;
  s_dma_error_t eng_err_rec = '0;

  dma_chan_sched #(.NUM_CH(4), .TIMEOUT_CYC(65535)) u_dut_a (
    .clk(clk), .rstn(rstn), .ch_req_i(ch_req), .ch_desc_i(ch_desc),
    .ch_ack_o(ack_a), .ch_done_o(done_a), .ch_err_o(err_a), .err_info_o(err_info_a),
    .timeout_o(timeout_a), .busy_o(busy_a), .cur_ch_o(cur_ch_a), .dma_go_o(go_a),
    .dma_desc_o(desc_a), .dma_stats_i(dma_stats), .dma_error_i(dma_error)
  );

  dma_chan_sched #(.NUM_CH(4), .TIMEOUT_CYC(8)) u_dut_b (
    .clk(clk), .rstn(rstn), .ch_req_i(ch_req), .ch_desc_i(ch_desc),
    .ch_ack_o(ack_b), .ch_done_o(done_b), .ch_err_o(err_b), .err_info_o(err_info_b),
    .timeout_o(timeout_b), .busy_o(busy_b), .cur_ch_o(cur_ch_b), .dma_go_o(go_b),
    .dma_desc_o(desc_b), .dma_stats_i(dma_stats), .dma_error_i(dma_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Engine model driven just after each rising edge, following go from instance A.
  initial begin
    int cnt;
    cnt = 0;
    dma_stats = '0;
    dma_error = '0;
    forever begin
      @(posedge clk);
      #1;
      dma_stats.error = 1'b0;
      dma_error = eng_err_rec;
      if (!rstn || !go_a) begin
        cnt = 0;
        dma_stats.done = 1'b0;
        dma_stats.active = 1'b0;
      end else begin
        cnt++;
        dma_stats.active = 1'b1;
        if (eng_err_at != 0 && cnt == eng_err_at) dma_stats.error = 1'b1;
        if (eng_force || (!eng_hang && cnt >= eng_lat)) dma_stats.done = 1'b1;
      end
    end
  end

  // Ack and done must never share a cycle on either instance.
  initial forever begin
    @(negedge clk);
    if (((ack_a & done_a) != 4'b0) || ((ack_b & done_b) != 4'b0)) overlap_n++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic wait_ack(input string tag, input int exp_ch);
    int ch;
    ch = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ack_a != 4'b0) begin
        ch = oh2i(ack_a);
        break;
      end
    end
    chk({tag, "_ack"}, 96'(ch), 96'(exp_ch));
    if (ch >= 0) ch_req &= ~(4'b0001 << ch);
  endtask

  task automatic wait_done(input string tag, input int exp_ch, input logic exp_err);
    int   ch;
    logic e;
    ch = -1;
    e  = 1'bx;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_a != 4'b0) begin
        ch = oh2i(done_a);
        e  = |err_a;
        break;
      end
    end
    chk({tag, "_done_ch"}, 96'(ch), 96'(exp_ch));
    chk({tag, "_done_err"}, 96'(e), 96'(exp_err));
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50; k++) begin
      if (!busy_a) break;
      @(negedge clk);
    end
    chk({tag, "_idle"}, 96'(busy_a), 96'(1'b0));
  endtask

  initial begin
    int go_hi, tmo_at, tmo_n, tmo_a;
    ch_req  = 4'b0;
    ch_desc = '0;
    ch_desc[0] = '{src_addr: 32'h0000_0100, dst_addr: 32'h0000_0200, num_bytes: 16'd32};
    ch_desc[1] = '{src_addr: 32'h0000_1100, dst_addr: 32'h0000_1200, num_bytes: 16'd128};
    ch_desc[2] = '{src_addr: 32'h0000_A000, dst_addr: 32'h0000_B000, num_bytes: 16'd64};
    ch_desc[3] = '{src_addr: 32'h0000_3100, dst_addr: 32'h0000_3200, num_bytes: 16'd16};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ack",      96'(ack_a),      96'(4'b0));
    chk("rst_done",     96'(done_a),     96'(4'b0));
    chk("rst_err",      96'(err_a),      96'(4'b0));
    chk("rst_busy",     96'(busy_a),     96'(1'b0));
    chk("rst_go",       96'(go_a),       96'(1'b0));
    chk("rst_cur_ch",   96'(cur_ch_a),   96'(2'd0));
    chk("rst_desc",     96'(desc_a),     96'(0));
    chk("rst_timeout",  96'(timeout_a),  96'(1'b0));
    chk("rst_err_info", 96'(err_info_a), 96'(0));
    chk("rst_b_desc",   96'(desc_b),     96'(0));
    chk("rst_b_info",   96'(err_info_b), 96'(0));
    chk("rst_b_cur",    96'(cur_ch_b),   96'(2'd0));
    rstn = 1'b1;

    // Round-robin order with three simultaneous requesters, then ch0 vs ch3.
    eng_lat = 3;
    @(negedge clk);
    ch_req = 4'b1011;
    wait_ack("rr1", 0);  wait_done("rr1", 0, 1'b0);
    wait_ack("rr2", 1);  wait_done("rr2", 1, 1'b0);
    wait_ack("rr3", 3);  wait_done("rr3", 3, 1'b0);
    wait_idle("rr3");
    @(negedge clk);
    ch_req = 4'b1001;
    wait_ack("rr4", 0);  wait_done("rr4", 0, 1'b0);
    wait_ack("rr5", 3);  wait_done("rr5", 3, 1'b0);
    wait_idle("rr5");

    // Single request on ch2, engine done 10 cycles after go.
    eng_lat = 10;
    @(negedge clk);
    ch_req = 4'b0100;
    @(negedge clk);
    chk("t1_ack",    96'(ack_a),    96'(4'b0100));
    chk("t1_go",     96'(go_a),     96'(1'b1));
    chk("t1_busy",   96'(busy_a),   96'(1'b1));
    chk("t1_cur_ch", 96'(cur_ch_a), 96'(2'd2));
    chk("t1_desc",   96'(desc_a),   96'(ch_desc[2]));
    ch_req = 4'b0;
    go_hi = 0;
    for (int k = 0; k < 200; k++) begin
      if (done_a != 4'b0) break;
      if (go_a) go_hi++;
      @(negedge clk);
    end
    chk("t1_go_cycles", 96'(go_hi),  96'(10));
    chk("t1_done",      96'(done_a), 96'(4'b0100));
    chk("t1_err",       96'(err_a),  96'(4'b0));
    chk("t1_go_off",    96'(go_a),   96'(1'b0));
    wait_idle("t1");

    // Engine error mid-transfer on ch1, then a clean transfer keeps err_info.
    eng_err_at  = 4;
    eng_err_rec = '{src: DMA_ERR_RD, addr: 32'h0000_1000};
    @(negedge clk);
    ch_req = 4'b0010;
    wait_ack("t3", 1);
    wait_done("t3", 1, 1'b1);
    chk("t3_info_addr", 96'(err_info_a.addr), 96'(32'h0000_1000));
    chk("t3_info_src",  96'(err_info_a.src),  96'(DMA_ERR_RD));
    eng_err_at  = 0;
    eng_err_rec = '{src: DMA_ERR_WR, addr: 32'h0000_2222};
    wait_idle("t3");
    @(negedge clk);
    ch_req = 4'b0100;
    wait_ack("t3c", 2);
    wait_done("t3c", 2, 1'b0);
    chk("t3c_info_addr", 96'(err_info_a.addr), 96'(32'h0000_1000));
    chk("t3c_info_src",  96'(err_info_a.src),  96'(DMA_ERR_RD));
    wait_idle("t3c");

    // Zero-length descriptor on ch3 completes locally.
    ch_desc[3].num_bytes = 16'd0;
    @(negedge clk);
    ch_req = 4'b1000;
    @(negedge clk);
    chk("t4_ack",  96'(ack_a),  96'(4'b1000));
    chk("t4_go1",  96'(go_a),   96'(1'b0));
    chk("t4_done0", 96'(done_a), 96'(4'b0));
    ch_req = 4'b0;
    @(negedge clk);
    chk("t4_done", 96'(done_a), 96'(4'b1000));
    chk("t4_err",  96'(err_a),  96'(4'b0));
    chk("t4_ack0", 96'(ack_a),  96'(4'b0));
    chk("t4_go2",  96'(go_a),   96'(1'b0));
    chk("t4_busy", 96'(busy_a), 96'(1'b0));
    ch_desc[3].num_bytes = 16'd16;

    // Watchdog: instance B expires on the 8th GO/WAIT cycle, A does not.
    eng_hang = 1'b1;
    @(negedge clk);
    ch_req = 4'b0001;
    tmo_at = 0; tmo_n = 0; tmo_a = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) ch_req = 4'b0;
      if (timeout_b) begin
        if (tmo_at == 0) tmo_at = k;
        tmo_n++;
      end
      if (timeout_a) tmo_a++;
    end
    chk("t5_tmo_cycle", 96'(tmo_at), 96'(8));
    chk("t5_tmo_count", 96'(tmo_n),  96'(1));
    chk("t5_tmo_a",     96'(tmo_a),  96'(0));
    chk("t5_go_held",   96'(go_b),   96'(1'b1));
    eng_force = 1'b1;
    wait_done("t5", 0, 1'b0);
    chk("t5_b_done", 96'(done_b), 96'(4'b0001));
    chk("t5_b_err",  96'(err_b),  96'(4'b0001));
    wait_idle("t5");
    eng_force = 1'b0;
    eng_hang  = 1'b0;

    // Reset during WAIT, then ch0 wins over ch3 from the reset pointer.
    eng_lat = 50;
    @(negedge clk);
    ch_req = 4'b0100;
    wait_ack("t6", 2);
    repeat (5) @(negedge clk);
    chk("t6_pre_go", 96'(go_a), 96'(1'b1));
    rstn = 1'b0;
    #1;
    chk("t6_go",   96'(go_a),   96'(1'b0));
    chk("t6_busy", 96'(busy_a), 96'(1'b0));
    chk("t6_ack",  96'(ack_a),  96'(4'b0));
    chk("t6_done", 96'(done_a), 96'(4'b0));
    chk("t6_go_b", 96'(go_b),   96'(1'b0));
    ch_req  = 4'b1001;
    eng_lat = 5;
    repeat (2) @(negedge clk);
    chk("t6_done_rst", 96'(done_a), 96'(4'b0));
    rstn = 1'b1;
    wait_ack("t6r1", 0);  wait_done("t6r1", 0, 1'b0);
    wait_ack("t6r2", 3);  wait_done("t6r2", 3, 1'b0);
    wait_idle("t6r2");

    chk("ack_done_overlap", 96'(overlap_n), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
